// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  localparam int REG_W_DEF = 5;

  // Register $zero never carries a real dependency.
  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and hold/bubble selects between pipeline and controller
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
);

  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic             branch_taken_i;
  logic             mc_start_i;
  logic             ext_stall_i;

  logic             pc_remain_o;
  logic             ifid_remain_o;
  logic             idex_remain_o;
  logic             exmem_remain_o;
  logic             memwb_remain_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             exmem_flush_o;

  modport master (
    output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, mc_start_i, ext_stall_i,
    input  pc_remain_o, ifid_remain_o, idex_remain_o, exmem_remain_o, memwb_remain_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o
  );

  modport slave (
    input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, mc_start_i, ext_stall_i,
    output pc_remain_o, ifid_remain_o, idex_remain_o, exmem_remain_o, memwb_remain_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// rtl/pipe_hazard_ctrl_perf_cnt.sv - wrapping event counter with synchronous clear
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear beats a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_hazard_ctrl_if.slave hz,
  input  logic             cnt_clr_i,
  output logic             mc_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int MC_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  state_e          state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;

  logic load_use;
  logic branch_evt;
  logic pc_remain, ifid_remain, idex_remain, exmem_remain, memwb_remain;
  logic ifid_flush, idex_flush, exmem_flush;

  assign load_use = hz.idex_memread_i
                  & (hz.idex_rt_i != REG_W'(ZERO_REG))
                  & ((hz.idex_rt_i == hz.ifid_rs_i)
                     | (hz.ifid_uses_rt_i & (hz.idex_rt_i == hz.ifid_rt_i)));

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    branch_evt   = 1'b0;
    pc_remain    = 1'b0;
    ifid_remain  = 1'b0;
    idex_remain  = 1'b0;
    exmem_remain = 1'b0;
    memwb_remain = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;

    if (hz.ext_stall_i) begin
      // Freeze the whole pipe, but let the multi-cycle unit keep counting down.
      pc_remain    = 1'b1;
      ifid_remain  = 1'b1;
      idex_remain  = 1'b1;
      exmem_remain = 1'b1;
      memwb_remain = 1'b1;
      if (mc_cnt_q != '0) begin
        mc_cnt_d = mc_cnt_q - 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.mc_start_i) begin
            pc_remain   = 1'b1;
            ifid_remain = 1'b1;
            idex_remain = 1'b1;
            exmem_flush = 1'b1;
            mc_cnt_d    = MC_W'(MC_LAT - 2);
            state_d     = MC_BUSY;
          end else if (hz.branch_taken_i) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            branch_evt = 1'b1;
          end else if (load_use) begin
            pc_remain   = 1'b1;
            ifid_remain = 1'b1;
            idex_flush  = 1'b1;
          end
        end
        MC_BUSY: begin
          if (mc_cnt_q != '0) begin
            pc_remain   = 1'b1;
            ifid_remain = 1'b1;
            idex_remain = 1'b1;
            exmem_flush = 1'b1;
            mc_cnt_d    = mc_cnt_q - 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign hz.pc_remain_o    = pc_remain;
  assign hz.ifid_remain_o  = ifid_remain;
  assign hz.idex_remain_o  = idex_remain;
  assign hz.exmem_remain_o = exmem_remain;
  assign hz.memwb_remain_o = memwb_remain;
  assign hz.ifid_flush_o   = ifid_flush;
  assign hz.idex_flush_o   = idex_flush;
  assign hz.exmem_flush_o  = exmem_flush;
  assign mc_busy_o         = (state_q == MC_BUSY);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (pc_remain),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (branch_evt),
    .clr_i (cnt_clr_i),
    .cnt_o (flush_cnt_o)
  );

endmodule
